// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Two-source (ALU, LSB) result buffering with round-robin
//               arbitration onto a single registered common data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ROB_IDX_WIDTH = 4,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clr_in,
  input  logic                     alu_in_valid,
  input  logic [ROB_IDX_WIDTH-1:0] alu_in_rob_index,
  input  logic [DATA_WIDTH-1:0]    alu_in_result,
  output logic                     alu_in_ready,
  input  logic                     lsb_in_valid,
  input  logic [ROB_IDX_WIDTH-1:0] lsb_in_rob_index,
  input  logic [DATA_WIDTH-1:0]    lsb_in_result,
  output logic                     lsb_in_ready,
  output logic                     cdb_valid,
  output logic [ROB_IDX_WIDTH-1:0] cdb_rob_index,
  output logic [DATA_WIDTH-1:0]    cdb_result,
  output logic                     cdb_src
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic                     active;
  logic [1:0]               in_valid;
  logic [1:0]               in_ready;
  logic [1:0]               push;
  logic [1:0]               pop;
  logic [1:0]               nonempty;
  logic [ROB_IDX_WIDTH-1:0] in_rob   [2];
  logic [DATA_WIDTH-1:0]    in_res   [2];
  logic [ROB_IDX_WIDTH-1:0] head_rob [2];
  logic [DATA_WIDTH-1:0]    head_res [2];

  logic                     grant_valid;
  logic                     grant_src;
  logic                     last_grant_q, last_grant_d;
  logic                     cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_WIDTH-1:0] cdb_rob_q, cdb_rob_d;
  logic [DATA_WIDTH-1:0]    cdb_res_q, cdb_res_d;
  logic                     cdb_src_q, cdb_src_d;

  assign active    = rdy_in && !clr_in;
  assign in_valid  = {lsb_in_valid, alu_in_valid};
  assign in_rob[0] = alu_in_rob_index;
  assign in_rob[1] = lsb_in_rob_index;
  assign in_res[0] = alu_in_result;
  assign in_res[1] = lsb_in_result;

  assign alu_in_ready = in_ready[0];
  assign lsb_in_ready = in_ready[1];

  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [ROB_IDX_WIDTH-1:0] rob_mem_q [FIFO_DEPTH];
    logic [ROB_IDX_WIDTH-1:0] rob_mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    res_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    res_mem_d [FIFO_DEPTH];

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign in_ready[s] = active && (count_q < DEPTH_CNT);
    // Index 0 means "no dependency": accepted on the handshake but never stored.
    assign push[s]     = in_valid[s] && in_ready[s] && (in_rob[s] != '0);
    assign nonempty[s] = (count_q != '0);
    assign head_rob[s] = rob_mem_q[head_q];
    assign head_res[s] = res_mem_q[head_q];

    always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      rob_mem_d = rob_mem_q;
      res_mem_d = res_mem_q;
      if (clr_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else if (rdy_in) begin
        if (push[s]) begin
          rob_mem_d[tail_q] = in_rob[s];
          res_mem_d[tail_q] = in_res[s];
          tail_d            = tail_q + PTR_W'(1);
        end
        if (pop[s]) begin
          head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          rob_mem_q[i] <= '0;
          res_mem_q[i] <= '0;
        end
      end else begin
        head_q    <= head_d;
        tail_q    <= tail_d;
        count_q   <= count_d;
        rob_mem_q <= rob_mem_d;
        res_mem_q <= res_mem_d;
      end
    end
  end

  always_comb begin
    grant_valid = active && (nonempty != 2'b00);
    grant_src   = (nonempty == 2'b11) ? ~last_grant_q : nonempty[1];
    pop         = 2'b00;
    if (grant_valid) begin
      pop[grant_src] = 1'b1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_d    = cdb_rob_q;
    cdb_res_d    = cdb_res_q;
    cdb_src_d    = cdb_src_q;
    if (clr_in) begin
      cdb_valid_d  = 1'b0;
      last_grant_d = SRC_LSB;
    end else if (rdy_in) begin
      if (grant_valid) begin
        cdb_valid_d  = 1'b1;
        cdb_rob_d    = head_rob[grant_src];
        cdb_res_d    = head_res[grant_src];
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_res_q    <= '0;
      cdb_src_q    <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_res_q    <= cdb_res_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_rob_index = cdb_rob_q;
  assign cdb_result    = cdb_res_q;
  assign cdb_src       = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Vector table, directed corner sequences and randomized traffic
//               against a queue-based reference model of the CDB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int DEPTH = 2;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clr_in;
  logic          alu_in_valid, lsb_in_valid;
  logic [RW-1:0] alu_in_rob_index, lsb_in_rob_index;
  logic [DW-1:0] alu_in_result, lsb_in_result;
  logic          alu_in_ready, lsb_in_ready;
  logic          cdb_valid, cdb_src;
  logic [RW-1:0] cdb_rob_index;
  logic [DW-1:0] cdb_result;

  cdb_arbiter #(.DATA_WIDTH(DW), .ROB_IDX_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .alu_in_valid(alu_in_valid), .alu_in_rob_index(alu_in_rob_index),
    .alu_in_result(alu_in_result), .alu_in_ready(alu_in_ready),
    .lsb_in_valid(lsb_in_valid), .lsb_in_rob_index(lsb_in_rob_index),
    .lsb_in_result(lsb_in_result), .lsb_in_ready(lsb_in_ready),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index),
    .cdb_result(cdb_result), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source plus the broadcast register image.
  typedef struct packed {
    logic [RW-1:0] rob;
    logic [DW-1:0] res;
  } ent_t;

  ent_t          mq_a[$];
  ent_t          mq_l[$];
  bit            m_last;
  bit            m_cv;
  bit            m_csrc;
  logic [RW-1:0] m_crob;
  logic [DW-1:0] m_cres;

  task automatic model_reset();
    mq_a.delete();
    mq_l.delete();
    m_last = 1'b1;
    m_cv   = 1'b0;
    m_csrc = 1'b0;
    m_crob = '0;
    m_cres = '0;
  endtask

  task automatic model_edge();
    bit   ra, rl, g;
    ent_t e;
    if (clr_in) begin
      mq_a.delete();
      mq_l.delete();
      m_cv   = 1'b0;
      m_last = 1'b1;
    end else if (rdy_in) begin
      ra = mq_a.size() < DEPTH;
      rl = mq_l.size() < DEPTH;
      if (mq_a.size() == 0 && mq_l.size() == 0) begin
        m_cv = 1'b0;
      end else begin
        if (mq_a.size() != 0 && mq_l.size() != 0) g = !m_last;
        else g = (mq_l.size() != 0);
        e      = g ? mq_l.pop_front() : mq_a.pop_front();
        m_cv   = 1'b1;
        m_crob = e.rob;
        m_cres = e.res;
        m_csrc = g;
        m_last = g;
      end
      if (alu_in_valid && ra && alu_in_rob_index != 0) mq_a.push_back({alu_in_rob_index, alu_in_result});
      if (lsb_in_valid && rl && lsb_in_rob_index != 0) mq_l.push_back({lsb_in_rob_index, lsb_in_result});
    end
  endtask

  logic cap_ar, cap_lr;

  task automatic set_in(input bit rdy, input bit clr, input bit av, input int arob,
                        input logic [DW-1:0] ares, input bit lv, input int lrob,
                        input logic [DW-1:0] lres);
    rdy_in = rdy; clr_in = clr;
    alu_in_valid = av; alu_in_rob_index = RW'(arob); alu_in_result = ares;
    lsb_in_valid = lv; lsb_in_rob_index = RW'(lrob); lsb_in_result = lres;
  endtask

  // One clock: check ready against the model, advance model and DUT, check the bus.
  task automatic step();
    bit m_ra, m_rl;
    #1;
    cap_ar = alu_in_ready;
    cap_lr = lsb_in_ready;
    m_ra = rdy_in && !clr_in && (mq_a.size() < DEPTH);
    m_rl = rdy_in && !clr_in && (mq_l.size() < DEPTH);
    chk("model_alu_ready", 32'(cap_ar), 32'(m_ra));
    chk("model_lsb_ready", 32'(cap_lr), 32'(m_rl));
    model_edge();
    @(posedge clk_in);
    #1;
    chk("model_cdb_valid", 32'(cdb_valid), 32'(m_cv));
    chk("model_cdb_rob", 32'(cdb_rob_index), 32'(m_crob));
    chk("model_cdb_result", cdb_result, m_cres);
    chk("model_cdb_src", 32'(cdb_src), 32'(m_csrc));
    if (cdb_valid) chk("rob_zero_broadcast", 32'(cdb_rob_index != 0), 32'd1);
  endtask

  task automatic idle(input bit rdy);
    set_in(rdy, 1'b0, 1'b0, 0, '0, 1'b0, 0, '0);
  endtask

  typedef struct packed {
    logic          rdy, clr, av;
    logic [RW-1:0] arob;
    logic [DW-1:0] ares;
    logic          lv;
    logic [RW-1:0] lrob;
    logic [DW-1:0] lres;
    logic          ea, el, ecv;
    logic [RW-1:0] erob;
    logic [DW-1:0] eres;
    logic          esrc;
  } vec_t;

  vec_t tbl[17];

  task automatic row(input int i, input bit rdy, input bit clr, input bit av, input int arob,
                     input bit lv, input int lrob, input bit ea, input bit el, input bit ecv,
                     input int erob, input logic [DW-1:0] eres, input bit esrc);
    tbl[i].rdy = rdy; tbl[i].clr = clr;
    tbl[i].av = av; tbl[i].arob = RW'(arob); tbl[i].ares = 32'hA000_0000 + 32'(arob);
    tbl[i].lv = lv; tbl[i].lrob = RW'(lrob); tbl[i].lres = 32'hB000_0000 + 32'(lrob);
    tbl[i].ea = ea; tbl[i].el = el; tbl[i].ecv = ecv;
    tbl[i].erob = RW'(erob); tbl[i].eres = eres; tbl[i].esrc = esrc;
  endtask

  initial begin
    //        i rdy clr av ar lv lr   ea el cv rob  result         src
    row( 0, 1, 0, 0, 0, 0,  0,  1, 1, 0,  0, 32'h0,          0);
    row( 1, 1, 0, 1, 3, 0,  0,  1, 1, 0,  0, 32'h0,          0);
    row( 2, 1, 0, 0, 0, 0,  0,  1, 1, 1,  3, 32'h1234_5678,  0);
    row( 3, 1, 0, 0, 0, 0,  0,  1, 1, 0,  3, 32'h1234_5678,  0);
    row( 4, 1, 1, 0, 0, 0,  0,  0, 0, 0,  3, 32'h1234_5678,  0);
    row( 5, 1, 0, 1, 1, 1,  9,  1, 1, 0,  3, 32'h1234_5678,  0);
    row( 6, 1, 0, 1, 2, 1, 10,  1, 1, 1,  1, 32'hA000_0001,  0);
    row( 7, 1, 0, 1, 3, 1, 11,  1, 0, 1,  9, 32'hB000_0009,  1);
    row( 8, 1, 0, 1, 4, 1, 11,  0, 1, 1,  2, 32'hA000_0002,  0);
    row( 9, 1, 0, 1, 4, 1, 12,  1, 0, 1, 10, 32'hB000_000A,  1);
    row(10, 1, 0, 1, 5, 1, 12,  0, 1, 1,  3, 32'hA000_0003,  0);
    row(11, 1, 0, 1, 5, 1, 13,  1, 0, 1, 11, 32'hB000_000B,  1);
    row(12, 1, 0, 1, 6, 1, 13,  0, 1, 1,  4, 32'hA000_0004,  0);
    row(13, 1, 0, 0, 0, 0,  0,  1, 0, 1, 12, 32'hB000_000C,  1);
    row(14, 1, 0, 0, 0, 0,  0,  1, 1, 1,  5, 32'hA000_0005,  0);
    row(15, 1, 0, 0, 0, 0,  0,  1, 1, 1, 13, 32'hB000_000D,  1);
    row(16, 1, 0, 0, 0, 0,  0,  1, 1, 0, 13, 32'hB000_000D,  1);
    tbl[1].ares = 32'h1234_5678;

    rst_in = 1'b0;
    idle(1'b0);
    model_reset();
    #3;
    chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("reset_cdb_rob", 32'(cdb_rob_index), 32'd0);
    chk("reset_cdb_result", cdb_result, 32'd0);
    chk("reset_cdb_src", 32'(cdb_src), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Single push, flush, then the eight-cycle tie with round robin.
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].rdy, tbl[i].clr, tbl[i].av, int'(tbl[i].arob), tbl[i].ares,
             tbl[i].lv, int'(tbl[i].lrob), tbl[i].lres);
      step();
      chk($sformatf("tbl%0d_alu_ready", i), 32'(cap_ar), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_lsb_ready", i), 32'(cap_lr), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_cdb_valid", i), 32'(cdb_valid), 32'(tbl[i].ecv));
      chk($sformatf("tbl%0d_cdb_rob", i), 32'(cdb_rob_index), 32'(tbl[i].erob));
      chk($sformatf("tbl%0d_cdb_result", i), cdb_result, tbl[i].eres);
      chk($sformatf("tbl%0d_cdb_src", i), 32'(cdb_src), 32'(tbl[i].esrc));
    end

    // Full boundary: LSB pushes three back-to-back against ALU traffic.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 1, 6 + k, 32'hA000_0100 + 32'(k), 1, 9 + k, 32'hB000_0100 + 32'(k));
      step();
      if (k == 2) chk("full_lsb_ready_third", 32'(cap_lr), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      idle(1'b1);
      step();
    end
    chk("drained_valid", 32'(cdb_valid), 32'd0);

    // rob_index 0 is accepted but never stored.
    set_in(1, 0, 1, 0, 32'hDEAD_0000, 1, 12, 32'hB000_0C0C);
    step();
    chk("rob0_alu_ready", 32'(cap_ar), 32'd1);
    idle(1'b1);
    step();
    chk("rob0_next_valid", 32'(cdb_valid), 32'd1);
    chk("rob0_next_src", 32'(cdb_src), 32'd1);
    chk("rob0_next_rob", 32'(cdb_rob_index), 32'd12);
    step();
    chk("rob0_never_broadcast", 32'(cdb_valid), 32'd0);

    // Flush with traffic in flight and new inputs on the flush cycle.
    set_in(1, 0, 1, 1, 32'hA1, 1, 2, 32'hB2);
    step();
    set_in(1, 0, 1, 3, 32'hA3, 1, 4, 32'hB4);
    step();
    set_in(1, 1, 1, 14, 32'hAE, 1, 15, 32'hBF);
    step();
    chk("flush_ready_alu", 32'(cap_ar), 32'd0);
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    set_in(1, 0, 1, 5, 32'hA5, 1, 6, 32'hB6);
    step();
    chk("post_flush_alu_ready", 32'(cap_ar), 32'd1);
    chk("post_flush_lsb_ready", 32'(cap_lr), 32'd1);
    chk("post_flush_no_old", 32'(cdb_valid), 32'd0);
    idle(1'b1);
    step();
    chk("post_flush_tie_src", 32'(cdb_src), 32'd0);
    chk("post_flush_tie_rob", 32'(cdb_rob_index), 32'd5);

    // Stall: rob 5 held on the bus while rdy_in is low.
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1, 7, 32'hA7, 1, 8, 32'hB8);
      step();
      chk("stall_alu_ready", 32'(cap_ar), 32'd0);
      chk("stall_valid", 32'(cdb_valid), 32'd1);
      chk("stall_rob", 32'(cdb_rob_index), 32'd5);
    end
    idle(1'b1);
    step();
    chk("resume_src", 32'(cdb_src), 32'd1);
    chk("resume_rob", 32'(cdb_rob_index), 32'd6);
    step();
    chk("resume_done", 32'(cdb_valid), 32'd0);

    // Asynchronous reset with both FIFOs holding entries.
    set_in(1, 0, 1, 1, 32'hA1, 1, 2, 32'hB2);
    step();
    set_in(1, 0, 1, 3, 32'hA3, 1, 4, 32'hB4);
    step();
    chk("pre_reset_valid", 32'(cdb_valid), 32'd1);
    idle(1'b1);
    #1;
    rst_in = 1'b0;
    model_reset();
    #1;
    chk("async_reset_valid", 32'(cdb_valid), 32'd0);
    chk("async_reset_rob", 32'(cdb_rob_index), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_reset_alu_ready", 32'(cap_ar), 32'd1);
      chk("post_reset_lsb_ready", 32'(cap_lr), 32'd1);
      chk("post_reset_no_bcast", 32'(cdb_valid), 32'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      set_in($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 70, int'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 99) < 70, int'($urandom_range(0, 15)), $urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
